// File: rtl/seq_arb_pkg.sv
// Shared types and helpers for the round-robin sequence-detector arbiter.
package seq_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    CLR    = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Index width for n items; never below one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/seq_detect_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, with wrap.
module rr_pick
  import seq_arb_pkg::*;
#(
  parameter  int unsigned NCH = 4,
  localparam int unsigned IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [IW-1:0]  o_idx,
  output logic           o_vld
);

  logic [NCH-1:0] w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotate so the pointer channel lands at bit 0
  assign w_rot = NCH'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    o_vld = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
        o_vld = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IW+1)'(NCH)) ? IW'(w_sum - (IW+1)'(NCH)) : IW'(w_sum);
  assign o_gnt = NCH'(1) << o_idx;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Time-shares one external Mealy sequence detector among NCH serial requesters.
// Optional stall timeout enabled by defining SEQ_ARB_TIMEOUT_EN.
module seq_detect_arbiter
  import seq_arb_pkg::*;
#(
  parameter  int unsigned NCH       = 4,
  parameter  int unsigned FRAME_LEN = 16,
  parameter  int unsigned CNT_W     = 8,
  parameter  int unsigned TIMEOUT   = 64,
  localparam int unsigned IW        = idx_w(NCH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NCH-1:0]   i_req,
  input  logic [NCH-1:0]   i_bit_vld,
  input  logic [NCH-1:0]   i_bit_in,
  output logic [NCH-1:0]   o_bit_rdy,
  output logic [NCH-1:0]   o_gnt,
  output logic             o_det_clr,
  output logic             o_det_en,
  output logic             o_det_din,
  input  logic             i_det_hit,
  output logic             o_busy,
  output logic             o_done,
  output logic [IW-1:0]    o_done_ch,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_aborted
);

  localparam int unsigned BC_W = idx_w(FRAME_LEN);

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_ptr, r_g;
  logic [NCH-1:0]   r_g_oh;
  logic [BC_W-1:0]  r_bitcnt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0]    r_done_ch;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_aborted;

  logic [NCH-1:0]   w_pick_gnt;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_vld;
  logic             w_accept, w_last, w_drop, w_tmo, w_end;

  rr_pick #(.NCH(NCH)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  assign w_accept  = (r_state == STREAM) && (|(i_bit_vld & r_g_oh));
  assign w_drop    = (r_state == STREAM) && !(|(i_req & r_g_oh));
  assign w_last    = w_accept && (r_bitcnt == BC_W'(FRAME_LEN - 1));
  assign w_end     = w_last || w_drop || w_tmo;
  assign w_cnt_nxt = (w_accept && i_det_hit && (r_cnt != {CNT_W{1'b1}}))
                     ? r_cnt + CNT_W'(1) : r_cnt;

`ifdef SEQ_ARB_TIMEOUT_EN
  localparam int unsigned SW = idx_w(TIMEOUT + 1);
  logic [SW-1:0] r_stall;

  // Counts consecutive STREAM cycles without an accepted bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall <= '0;
    end else if ((r_state != STREAM) || w_accept) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + SW'(1);
    end
  end

  assign w_tmo = (r_state == STREAM) && !w_accept && (r_stall == SW'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|i_req) w_state_nxt = ARB;
      ARB:     w_state_nxt = w_pick_vld ? CLR : IDLE;
      CLR:     w_state_nxt = STREAM;
      STREAM:  if (w_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_gnt     = '0;
    o_bit_rdy = '0;
    o_det_clr = 1'b0;
    o_det_en  = 1'b0;
    o_det_din = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (r_state)
      IDLE: o_busy = 1'b0;
      ARB:  ;
      CLR: begin
        o_gnt     = r_g_oh;
        o_det_clr = 1'b1;
      end
      STREAM: begin
        o_gnt     = r_g_oh;
        o_bit_rdy = r_g_oh;
        o_det_en  = w_accept;
        o_det_din = |(i_bit_in & r_g_oh);
      end
      DONE: begin
        o_gnt  = r_g_oh;
        o_done = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  // Session datapath: grant latch, bit/hit counters, result capture, RR pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_g         <= '0;
      r_g_oh      <= '0;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_done_ch   <= '0;
      r_match_cnt <= '0;
      r_aborted   <= 1'b0;
    end else begin
      if ((r_state == ARB) && w_pick_vld) begin
        r_g    <= w_pick_idx;
        r_g_oh <= w_pick_gnt;
      end
      if (r_state == CLR) begin
        r_bitcnt <= '0;
        r_cnt    <= '0;
      end else if (w_accept) begin
        r_bitcnt <= r_bitcnt + BC_W'(1);
        r_cnt    <= w_cnt_nxt;
      end
      // Results include the hit of the final accepted bit
      if ((r_state == STREAM) && w_end) begin
        r_done_ch   <= r_g;
        r_match_cnt <= w_cnt_nxt;
        r_aborted   <= w_drop || w_tmo;
      end
      if (r_state == DONE) begin
        r_ptr <= (r_g == IW'(NCH - 1)) ? '0 : r_g + IW'(1);
      end
    end
  end

  assign o_done_ch   = r_done_ch;
  assign o_match_cnt = r_match_cnt;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter: vector table plus hand-written session sequences.
`timescale 1ns/1ps
module tb_seq_detect_arbiter;

  localparam int FL = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] vld   = '0;
  logic [3:0] bin   = '0;
  logic       hit   = 1'b0;

  logic [3:0] rdy, gnt, rdy2, gnt2;
  logic       clr, en, din, busy, done, abrt;
  logic       clr2, en2, din2, busy2, done2, abrt2;
  logic [1:0] dch, dch2;
  logic [7:0] mcnt;
  logic [1:0] mcnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  vld;
    logic [3:0]  bin;
    logic        hit;
    logic [12:0] exp;   // {busy, gnt, rdy, clr, en, din, done}
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  seq_detect_arbiter #(.NCH(4), .FRAME_LEN(16), .CNT_W(8), .TIMEOUT(64)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_bit_vld(vld), .i_bit_in(bin),
    .o_bit_rdy(rdy), .o_gnt(gnt), .o_det_clr(clr), .o_det_en(en), .o_det_din(din),
    .i_det_hit(hit), .o_busy(busy), .o_done(done), .o_done_ch(dch),
    .o_match_cnt(mcnt), .o_aborted(abrt)
  );

  seq_detect_arbiter #(.NCH(4), .FRAME_LEN(16), .CNT_W(2), .TIMEOUT(64)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_bit_vld(vld), .i_bit_in(bin),
    .o_bit_rdy(rdy2), .o_gnt(gnt2), .o_det_clr(clr2), .o_det_en(en2), .o_det_din(din2),
    .i_det_hit(hit), .o_busy(busy2), .o_done(done2), .o_done_ch(dch2),
    .o_match_cnt(mcnt2), .o_aborted(abrt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    return 4'(1) << c;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_dut"},  32'({gnt, rdy, clr, en, din, busy, done, dch, mcnt, abrt}), 32'd0);
    chk({nm, "_dut2"}, 32'({gnt2, rdy2, clr2, en2, din2, busy2, done2, dch2, mcnt2, abrt2}), 32'd0);
  endtask

  task automatic wait_rdy(output int g);
    g = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vld = '0;
      hit = 1'b0;
      #1;
      if (|rdy) begin
        for (int c = 0; c < 4; c++) if (rdy[c]) g = c;
        break;
      end
    end
    chk("grant_seen", 32'(g >= 0), 32'd1);
  endtask

  // Streams bits to channel g until target accepts, then checks the done pulse
  task automatic run_stream(input int g, input int start_acc, input logic [15:0] hits,
                            input bit toggle, input int abort_after, output int n_acc);
    int target;
    int cyc;
    logic [3:0] g_oh;
    g_oh   = oh(g);
    target = (abort_after >= 0) ? abort_after : FL;
    n_acc  = start_acc;
    cyc    = 0;
    while (n_acc < target && cyc < 200) begin
      @(negedge clk);
      vld = (toggle && cyc[0]) ? 4'b0000 : g_oh;
      bin = 4'($urandom);
      hit = vld[g] ? hits[n_acc] : 1'b0;
      #1;
      chk("en_follows_vld", 32'(en), 32'(vld[g]));
      chk("rdy_granted_only", 32'(rdy), 32'(g_oh));
      if (en) begin
        chk("det_din", 32'(din), 32'(bin[g]));
        n_acc++;
      end
      cyc++;
    end
    chk("accept_count", 32'(n_acc), 32'(target));
    if (abort_after >= 0) begin
      @(negedge clk);
      req[g] = 1'b0;
      vld    = '0;
      hit    = 1'b0;
      #1;
      chk("abort_cycle_en", 32'(en), 32'd0);
      chk("abort_cycle_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    vld = '0;
    hit = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_no_en", 32'(en), 32'd0);
    chk("done_gnt", 32'(gnt), 32'(g_oh));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    int dn;

    tbl[0] = '{req: 4'b0010, vld: 4'b0000, bin: 4'b0000, hit: 1'b0, exp: {1'b0, 4'b0000, 4'b0000, 4'b0000}};
    tbl[1] = '{req: 4'b0010, vld: 4'b0000, bin: 4'b0000, hit: 1'b0, exp: {1'b1, 4'b0000, 4'b0000, 4'b0000}};
    tbl[2] = '{req: 4'b0010, vld: 4'b0000, bin: 4'b0000, hit: 1'b0, exp: {1'b1, 4'b0010, 4'b0000, 4'b1000}};
    tbl[3] = '{req: 4'b0010, vld: 4'b0010, bin: 4'b0010, hit: 1'b0, exp: {1'b1, 4'b0010, 4'b0010, 4'b0110}};
    tbl[4] = '{req: 4'b0010, vld: 4'b0000, bin: 4'b0000, hit: 1'b0, exp: {1'b1, 4'b0010, 4'b0010, 4'b0000}};
    tbl[5] = '{req: 4'b0010, vld: 4'b0010, bin: 4'b0000, hit: 1'b0, exp: {1'b1, 4'b0010, 4'b0010, 4'b0100}};

    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: channel 1, latency through IDLE/ARB/CLR, hits on bits 5 and 12
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req = tbl[i].req;
      vld = tbl[i].vld;
      bin = tbl[i].bin;
      hit = tbl[i].hit;
      #1;
      chk($sformatf("t1_vec%0d", i), 32'({busy, gnt, rdy, clr, en, din, done}), 32'(tbl[i].exp));
    end
    run_stream(1, 2, 16'h1020, 1'b0, -1, n);
    chk("t1_done_ch", 32'(dch), 32'd1);
    chk("t1_match_cnt", 32'(mcnt), 32'd2);
    chk("t1_match_cnt_w2", 32'(mcnt2), 32'd2);
    chk("t1_aborted", 32'(abrt), 32'd0);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("t1_after_done", 32'({busy, done}), 32'd0);
    chk("t1_cnt_held", 32'(mcnt), 32'd2);

    // T4: channel 2 aborts after 7 accepts, channel 3 pending
    @(negedge clk);
    req = 4'b1100;
    wait_rdy(g);
    chk("t4_grant", 32'(g), 32'd2);
    if (g >= 0) run_stream(g, 0, 16'h0055, 1'b0, 7, n);
    chk("t4_done_ch", 32'(dch), 32'd2);
    chk("t4_match_cnt", 32'(mcnt), 32'd4);
    chk("t4_aborted", 32'(abrt), 32'd1);

    // T3: channel 3 with toggling bit_vld
    wait_rdy(g);
    chk("t4_next_grant", 32'(g), 32'd3);
    if (g >= 0) run_stream(g, 0, 16'h8001, 1'b1, -1, n);
    chk("t3_en_pulses", 32'(n), 32'd16);
    chk("t3_done_ch", 32'(dch), 32'd3);
    chk("t3_match_cnt", 32'(mcnt), 32'd2);
    chk("t3_aborted", 32'(abrt), 32'd0);

    // T5: hit on every bit; narrow counter saturates
    @(negedge clk);
    req = 4'b0001;
    wait_rdy(g);
    chk("t5_grant", 32'(g), 32'd0);
    if (g >= 0) run_stream(g, 0, 16'hFFFF, 1'b0, -1, n);
    chk("t5_match_cnt", 32'(mcnt), 32'd16);
    chk("t5_match_cnt_sat", 32'(mcnt2), 32'd3);
    chk("t5_done_ch", 32'(dch), 32'd0);
    chk("t5_aborted", 32'(abrt), 32'd0);

    // T6: reset in the middle of a channel-1 session
    @(negedge clk);
    req = 4'b0010;
    wait_rdy(g);
    chk("t6_grant", 32'(g), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vld = 4'b0010;
      bin = 4'($urandom);
      hit = 1'b1;
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_reset");
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t6_in_reset", 32'({busy, done}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // T2: all channels held; grants rotate from channel 0
    for (int i = 0; i < 8; i++) begin
      wait_rdy(g);
      chk($sformatf("t2_grant%0d", i), 32'(g), 32'(i % 4));
      if (g >= 0) run_stream(g, 0, 16'h0000, 1'b0, -1, n);
      chk($sformatf("t2_done_ch%0d", i), 32'(dch), 32'(i % 4));
      chk($sformatf("t2_aborted%0d", i), 32'(abrt), 32'd0);
    end
    @(negedge clk);
    req = 4'b0000;

    // T7: granted channel never presents a bit
    @(negedge clk);
    req = 4'b0001;
    wait_rdy(g);
    chk("t7_grant", 32'(g), 32'd0);
`ifdef SEQ_ARB_TIMEOUT_EN
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      vld = '0;
      #1;
      if (done) begin
        n = k;
        break;
      end
    end
    chk("t7_timeout_latency", 32'(n >= 63 && n <= 66), 32'd1);
    chk("t7_aborted", 32'(abrt), 32'd1);
    chk("t7_done_ch", 32'(dch), 32'd0);
    chk("t7_match_cnt", 32'(mcnt), 32'd0);
    @(negedge clk);
    req = 4'b0000;
`else
    dn = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      vld = '0;
      #1;
      if (done) dn++;
    end
    chk("t7_no_timeout_done", 32'(dn), 32'd0);
    chk("t7_still_busy", 32'(busy), 32'd1);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("t7_drop_cycle_done", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    chk("t7_drop_done", 32'(done), 32'd1);
    chk("t7_drop_aborted", 32'(abrt), 32'd1);
    chk("t7_drop_cnt", 32'(mcnt), 32'd0);
`endif
    @(negedge clk);
    #1;
    chk("final_idle", 32'({busy, gnt, rdy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
